// File: rtl/mmio_io_ctrl_if.sv
// mmio_io_ctrl_if
//   CPU-side memory-mapped I/O bus shared by the CPU (master) and the
//   I/O controller (slave).
//   addr       CPU byte address
//   writedata  CPU store data
//   memwrite   CPU store strobe
//   is_io      address falls in the I/O window (addr[8])
//   io_rdata   I/O read data, zero when is_io=0
interface mmio_io_ctrl_if;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        is_io;
  logic [31:0] io_rdata;

  modport master (
    output addr,
    output writedata,
    output memwrite,
    input  is_io,
    input  io_rdata
  );

  modport slave (
    input  addr,
    input  writedata,
    input  memwrite,
    output is_io,
    output io_rdata
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl
//   Memory-mapped I/O controller between the CPU data bus and the board
//   peripherals: LED register, N-digit 7-seg display, debounced keys and
//   switches, key-press edge capture (write-1-to-clear) and a free-running
//   32-bit cycle timer.
//   Register map (one-hot select bits, valid only when addr[8]=1):
//     LEDS 0x104 (bit2)  HEX 0x108 (bit3)  KEY 0x110 (bit4)
//     SW   0x120 (bit5)  EDGE 0x140 (bit6) TIMER 0x180 (bit7)
// Ports
//   clk      system clock, all state on posedge
//   reset    synchronous, active-high
//   bus      CPU bus (slave modport): addr, writedata, memwrite, is_io, io_rdata
//   sw       raw switches, asynchronous
//   key      raw keys, asynchronous, 0 = pressed
//   ledr     LED register
//   hex_seg  digit i at [7i+6:7i], active-low segments {g,f,e,d,c,b,a}
module mmio_io_ctrl #(
  parameter int LED_W      = 10,
  parameter int SW_W       = 10,
  parameter int KEY_W      = 4,
  parameter int HEX_DIGITS = 6,
  parameter int DB_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_io_ctrl_if.slave           bus,
  input  logic [SW_W-1:0]         sw,
  input  logic [KEY_W-1:0]        key,
  output logic [LED_W-1:0]        ledr,
  output logic [7*HEX_DIGITS-1:0] hex_seg
);

  localparam int HEX_W = 4 * HEX_DIGITS;
  localparam int CW    = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_TC = CW'(DB_CYCLES);

  // Active-low 7-segment encoding, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] dec7seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------- decode
  logic sel_leds, sel_hex, sel_key, sel_sw, sel_edge, sel_timer;
  logic wr_en;

  assign bus.is_io = bus.addr[8];
  assign sel_leds  = bus.is_io & bus.addr[2];
  assign sel_hex   = bus.is_io & bus.addr[3];
  assign sel_key   = bus.is_io & bus.addr[4];
  assign sel_sw    = bus.is_io & bus.addr[5];
  assign sel_edge  = bus.is_io & bus.addr[6];
  assign sel_timer = bus.is_io & bus.addr[7];
  assign wr_en     = bus.memwrite & bus.is_io;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:9], bus.addr[1:0]};

  // ------------------------------------------------------------- registers
  logic [LED_W-1:0] led_q;
  logic [HEX_W-1:0] hex_q;
  logic [KEY_W-1:0] edge_q;
  logic [31:0]      timer_q;

  logic [KEY_W-1:0] key_s1, key_s2, key_db, key_db_nxt;
  logic [SW_W-1:0]  sw_s1, sw_s2, sw_db, sw_db_nxt;
  logic [CW-1:0]    key_cnt     [KEY_W];
  logic [CW-1:0]    key_cnt_nxt [KEY_W];
  logic [CW-1:0]    sw_cnt      [SW_W];
  logic [CW-1:0]    sw_cnt_nxt  [SW_W];
  logic [KEY_W-1:0] key_press;

  // Debounce: counter runs while the synchronised level disagrees with the
  // debounced level and clears as soon as they agree again. The debounced
  // bit flips once the counter has already reached DB_CYCLES and the levels
  // still disagree, so an input held stable flips DB_CYCLES+2 edges after
  // it is first sampled.
  always_comb begin
    key_db_nxt  = key_db;
    key_cnt_nxt = key_cnt;
    for (int i = 0; i < KEY_W; i++) begin
      if (key_s2[i] == key_db[i]) begin
        key_cnt_nxt[i] = '0;
      end else if (key_cnt[i] == DB_TC) begin
        key_db_nxt[i]  = ~key_db[i];
        key_cnt_nxt[i] = '0;
      end else begin
        key_cnt_nxt[i] = key_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    sw_db_nxt  = sw_db;
    sw_cnt_nxt = sw_cnt;
    for (int i = 0; i < SW_W; i++) begin
      if (sw_s2[i] == sw_db[i]) begin
        sw_cnt_nxt[i] = '0;
      end else if (sw_cnt[i] == DB_TC) begin
        sw_db_nxt[i]  = ~sw_db[i];
        sw_cnt_nxt[i] = '0;
      end else begin
        sw_cnt_nxt[i] = sw_cnt[i] + 1'b1;
      end
    end
  end

  // Press = debounced key falling from released (1) to pressed (0).
  assign key_press = key_db & ~key_db_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
      key_db <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
      sw_db  <= '0;
      for (int i = 0; i < KEY_W; i++) key_cnt[i] <= '0;
      for (int i = 0; i < SW_W; i++)  sw_cnt[i]  <= '0;
    end else begin
      key_s1  <= key;
      key_s2  <= key_s1;
      key_db  <= key_db_nxt;
      key_cnt <= key_cnt_nxt;
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      sw_db   <= sw_db_nxt;
      sw_cnt  <= sw_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= '0;
      hex_q   <= '0;
      edge_q  <= '0;
      timer_q <= '0;
    end else begin
      if (wr_en && sel_leds) led_q <= bus.writedata[LED_W-1:0];
      if (wr_en && sel_hex)  hex_q <= bus.writedata[HEX_W-1:0];

      // A press in the same cycle as a W1C clear wins.
      if (wr_en && sel_edge)
        edge_q <= (edge_q & ~bus.writedata[KEY_W-1:0]) | key_press;
      else
        edge_q <= edge_q | key_press;

      if (wr_en && sel_timer) timer_q <= bus.writedata;
      else                    timer_q <= timer_q + 32'd1;
    end
  end

  // ------------------------------------------------------------------ read
  always_comb begin
    bus.io_rdata = '0;
    if (sel_leds)       bus.io_rdata = 32'(led_q);
    else if (sel_hex)   bus.io_rdata = 32'(hex_q);
    else if (sel_key)   bus.io_rdata = 32'(key_db);
    else if (sel_sw)    bus.io_rdata = 32'(sw_db);
    else if (sel_edge)  bus.io_rdata = 32'(edge_q);
    else if (sel_timer) bus.io_rdata = timer_q;
  end

  // --------------------------------------------------------------- outputs
  assign ledr = led_q;

  for (genvar g = 0; g < HEX_DIGITS; g++) begin : g_digit
    assign hex_seg[7*g +: 7] = dec7seg(hex_q[4*g +: 4]);
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
module tb_mmio_io_ctrl;
  localparam int LED_W = 10, SW_W = 10, KEY_W = 4, HEX_DIGITS = 6, DB_CYCLES = 4;

  logic                    clk;
  logic                    reset;
  logic [SW_W-1:0]         sw;
  logic [KEY_W-1:0]        key;
  logic [LED_W-1:0]        ledr;
  logic [7*HEX_DIGITS-1:0] hex_seg;

  mmio_io_ctrl_if bus ();

  mmio_io_ctrl #(
    .LED_W(LED_W), .SW_W(SW_W), .KEY_W(KEY_W),
    .HEX_DIGITS(HEX_DIGITS), .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .sw(sw), .key(key), .ledr(ledr), .hex_seg(hex_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [63:0] exp_q[$];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d];
  endfunction

  function automatic logic [7*HEX_DIGITS-1:0] hex_model(input logic [31:0] v);
    logic [7*HEX_DIGITS-1:0] r;
    for (int i = 0; i < HEX_DIGITS; i++) r[7*i +: 7] = seg_of(v[4*i +: 4]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.writedata = d; bus.memwrite = 1'b1;
    tick();
    bus.memwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] got, exp;
    logic [31:0] addrs [6];
    logic [31:0] vals  [6];
    addrs = '{32'h104, 32'h108, 32'h110, 32'h120, 32'h140, 32'h180};
    vals  = '{32'h0, 32'h0, 32'hF, 32'h0, 32'h0, 32'h0};
    reset = 1'b1; key = '1; sw = '0;
    bus.addr = 32'h0; bus.writedata = 32'h0; bus.memwrite = 1'b0;
    tick(); tick(); tick();
    exp_q.push_back(64'(ledr === '0 ? 0 : 1));
    exp_q.push_back(64'h0);
    got = exp_q.pop_front(); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_ledr: got %h exp 0", ledr); end
    exp_q.push_back(64'(hex_model(32'h0)));
    got = 64'(hex_seg); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_hex_seg: got %h exp %h", got, exp); end
    for (int i = 0; i < 6; i++) begin
      bus.addr = addrs[i]; exp_q.push_back(64'(vals[i])); #1;
      got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rst_read_%h: got %h exp %h", addrs[i], got, exp);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_leds();
    logic [63:0] got, exp;
    wr(32'h104, 32'h3FF);
    bus.addr = 32'h104; exp_q.push_back(64'h3FF); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL leds_rd: got %h exp %h", got, exp); end
    exp_q.push_back(64'h3FF);
    got = 64'(ledr); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL leds_port: got %h exp %h", got, exp); end
    bus.addr = 32'h004; exp_q.push_back(64'h0); #1;
    got = {31'h0, bus.is_io, bus.io_rdata}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL ram_addr is_io/rdata: got %h exp %h", got, exp); end
    bus.addr = 32'h100; exp_q.push_back(64'h1_0000_0000); #1;
    got = {31'h0, bus.is_io, bus.io_rdata}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL no_select: got %h exp %h", got, exp); end
  endtask

  task automatic test_hex();
    logic [63:0] got, exp;
    wr(32'h108, 32'h0012_3456);
    exp_q.push_back(64'(hex_model(32'h0012_3456)));
    got = 64'(hex_seg); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL hex_digits: got %h exp %h", got, exp); end
    wr(32'h10C, 32'hFFFF_FABC);
    bus.addr = 32'h10C; exp_q.push_back(64'h2BC); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL multi_rd_prio: got %h exp %h", got, exp); end
    bus.addr = 32'h108; exp_q.push_back(64'hFF_FABC); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL multi_wr_hex: got %h exp %h", got, exp); end
    exp_q.push_back(64'(hex_model(32'hFF_FABC)));
    got = 64'(hex_seg); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL multi_wr_seg: got %h exp %h", got, exp); end
    wr(32'h130, 32'h0);
    bus.addr = 32'h110; exp_q.push_back(64'hF); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL key_readonly: got %h exp %h", got, exp); end
  endtask

  task automatic test_debounce();
    logic [63:0] got, exp;
    key[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bus.addr = 32'h110; exp_q.push_back(64'hF); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL key_edge5: got %h exp %h", got, exp); end
    tick();
    bus.addr = 32'h110; exp_q.push_back(64'hE); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL key_edge6: got %h exp %h", got, exp); end
    bus.addr = 32'h140; exp_q.push_back(64'h1); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL edge_press: got %h exp %h", got, exp); end
    tick();
    key[2] = 1'b0; tick(); tick(); tick(); key[2] = 1'b1;
    key[0] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.addr = 32'h110; exp_q.push_back(64'hF); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch_release_key: got %h exp %h", got, exp); end
    bus.addr = 32'h140; exp_q.push_back(64'h1); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch_release_edge: got %h exp %h", got, exp); end
    tick();
    sw = 10'h2AA;
    for (int i = 0; i < 6; i++) tick();
    bus.addr = 32'h120; exp_q.push_back(64'h0); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL sw_edge5: got %h exp %h", got, exp); end
    tick();
    bus.addr = 32'h120; exp_q.push_back(64'h2AA); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL sw_edge6: got %h exp %h", got, exp); end
  endtask

  task automatic test_edge_w1c();
    logic [63:0] got, exp;
    tick();
    key[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    wr(32'h140, 32'h1);
    bus.addr = 32'h140; exp_q.push_back(64'h2); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL edge_set_wins: got %h exp %h", got, exp); end
    bus.addr = 32'h110; exp_q.push_back(64'hD); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL key1_level: got %h exp %h", got, exp); end
    wr(32'h140, 32'h2);
    bus.addr = 32'h140; exp_q.push_back(64'h0); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL edge_w1c: got %h exp %h", got, exp); end
    key[1] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_timer();
    logic [63:0] got, exp;
    logic [31:0] seq [3];
    seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 3; i++) exp_q.push_back(64'(seq[i]));
    wr(32'h180, 32'hFFFF_FFFE);
    bus.addr = 32'h180;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL timer_wrap_%0d: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [63:0] got, exp;
    wr(32'h104, 32'h155);
    key[3] = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    wr(32'h104, 32'h0AA);
    tick();
    exp_q.push_back(64'h0);
    got = 64'(ledr); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst2_ledr: got %h exp %h", got, exp); end
    bus.addr = 32'h110; exp_q.push_back(64'hF); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst2_key: got %h exp %h", got, exp); end
    bus.addr = 32'h180; exp_q.push_back(64'h0); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst2_timer: got %h exp %h", got, exp); end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bus.addr = 32'h110; exp_q.push_back(64'hF); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst2_key_edge5: got %h exp %h", got, exp); end
    bus.addr = 32'h140; exp_q.push_back(64'h0); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst2_edge_clear: got %h exp %h", got, exp); end
    tick();
    bus.addr = 32'h110; exp_q.push_back(64'h7); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst2_key_edge6: got %h exp %h", got, exp); end
    bus.addr = 32'h140; exp_q.push_back(64'h8); #1;
    got = 64'(bus.io_rdata); exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL rst2_edge_press: got %h exp %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_leds();
    test_hex();
    test_debounce();
    test_edge_w1c();
    test_timer();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
